// File: rtl/tree_path_encoder_if.sv
// Request, config and field-stream signals of the tree path encoder.
// The master side drives requests and config; the slave side is the encoder.
interface tree_path_encoder_if #(
    parameter int NODE_COUNT = 32,
    parameter int MAX_DEPTH  = 8,
    parameter int FIELD_ID_W = 5
);
    localparam int NODE_IDX_W = $clog2(NODE_COUNT);
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);

    logic                  cfg_we_i;
    logic [NODE_IDX_W-1:0] cfg_node_i;
    logic [NODE_IDX_W-1:0] cfg_parent_i;
    logic [FIELD_ID_W-1:0] cfg_field_id_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [NODE_IDX_W-1:0] req_node_i;
    logic                  field_valid_o;
    logic                  field_ready_i;
    logic [FIELD_ID_W-1:0] field_id_o;
    logic [DEPTH_W-1:0]    field_depth_o;
    logic                  field_last_o;
    logic                  done_o;
    logic                  err_o;
    logic                  busy_o;

    modport master (
        output cfg_we_i, cfg_node_i, cfg_parent_i, cfg_field_id_i,
        output req_valid_i, req_node_i, field_ready_i,
        input  req_ready_o, field_valid_o, field_id_o, field_depth_o,
        input  field_last_o, done_o, err_o, busy_o
    );

    modport slave (
        input  cfg_we_i, cfg_node_i, cfg_parent_i, cfg_field_id_i,
        input  req_valid_i, req_node_i, field_ready_i,
        output req_ready_o, field_valid_o, field_id_o, field_depth_o,
        output field_last_o, done_o, err_o, busy_o
    );
endinterface

// File: rtl/tree_path_encoder.sv
// Walks the configured node tree from a target node up to the root, then
// streams the root-to-node field IDs one beat per handshake.
module tree_path_encoder #(
    parameter int NODE_COUNT = 32,
    parameter int MAX_DEPTH  = 8,
    parameter int FIELD_ID_W = 5
) (
    input logic                clk_i,
    input logic                reset_i,
    tree_path_encoder_if.slave bus
);
    localparam int NODE_IDX_W = $clog2(NODE_COUNT);
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);
    localparam int STK_W      = $clog2(MAX_DEPTH);
    localparam int TBL_SIZE   = 1 << NODE_IDX_W;

    typedef enum logic [2:0] {IDLE, CLIMB, EMIT, DONE, ERR} state_t;

    state_t                state, state_nxt;
    logic [NODE_IDX_W-1:0] cur, cur_nxt;
    logic [DEPTH_W-1:0]    count, count_nxt;
    logic [DEPTH_W-1:0]    total, total_nxt;
    logic                  push;
    logic [STK_W-1:0]      top_idx;
    logic [STK_W-1:0]      push_idx;

    // Table padded to a power of two so any index reads a defined (zero) entry
    logic [NODE_IDX_W-1:0] parent_tbl [TBL_SIZE];
    logic [FIELD_ID_W-1:0] field_tbl  [TBL_SIZE];
    logic [FIELD_ID_W-1:0] stack      [MAX_DEPTH];

    logic cfg_hit;
    assign cfg_hit = bus.cfg_we_i && (state == IDLE) && (bus.cfg_node_i != '0)
                     && (32'(bus.cfg_node_i) < NODE_COUNT);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                parent_tbl[i] <= '0;
                field_tbl[i]  <= '0;
            end
        end else if (cfg_hit) begin
            parent_tbl[bus.cfg_node_i] <= bus.cfg_parent_i;
            field_tbl[bus.cfg_node_i]  <= bus.cfg_field_id_i;
        end
    end

    assign push_idx = STK_W'(count);
    assign top_idx  = STK_W'(count - 1'b1);

    always_ff @(posedge clk_i) begin
        if (push) stack[push_idx] <= field_tbl[cur];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
            cur   <= '0;
            count <= '0;
            total <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            count <= count_nxt;
            total <= total_nxt;
        end
    end

    assign bus.busy_o = (state != IDLE);

    always_comb begin
        state_nxt         = state;
        cur_nxt           = cur;
        count_nxt         = count;
        total_nxt         = total;
        push              = 1'b0;
        bus.req_ready_o   = 1'b0;
        bus.field_valid_o = 1'b0;
        bus.field_id_o    = '0;
        bus.field_depth_o = '0;
        bus.field_last_o  = 1'b0;
        bus.done_o        = 1'b0;
        bus.err_o         = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    cur_nxt   = bus.req_node_i;
                    count_nxt = '0;
                    total_nxt = '0;
                    state_nxt = (bus.req_node_i == '0) ? DONE : CLIMB;
                end
            end
            CLIMB: begin
                push      = 1'b1;
                count_nxt = count + 1'b1;
                cur_nxt   = parent_tbl[cur];
                // Reaching the root wins over the depth limit, so a full-depth path is legal
                if (parent_tbl[cur] == '0) begin
                    total_nxt = count + 1'b1;
                    state_nxt = EMIT;
                end else if (count + 1'b1 == DEPTH_W'(MAX_DEPTH)) begin
                    state_nxt = ERR;
                end
            end
            EMIT: begin
                bus.field_valid_o = 1'b1;
                bus.field_id_o    = stack[top_idx];
                bus.field_depth_o = total - count + 1'b1;
                bus.field_last_o  = (count == DEPTH_W'(1));
                if (bus.field_ready_i) begin
                    count_nxt = count - 1'b1;
                    if (count == DEPTH_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_nxt  = IDLE;
            end
            ERR: begin
                bus.err_o = 1'b1;
                count_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tree_path_encoder.sv
// Directed and randomized checks of tree_path_encoder against a path model
// built from parent/field arrays and a queue.
module tb_tree_path_encoder;
    localparam int NODE_COUNT = 32;
    localparam int MAX_DEPTH  = 8;
    localparam int FIELD_ID_W = 5;
    localparam int NIW        = $clog2(NODE_COUNT);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int par [NODE_COUNT];
    int fld [NODE_COUNT];
    int exp_q[$];

    tree_path_encoder_if #(.NODE_COUNT(NODE_COUNT), .MAX_DEPTH(MAX_DEPTH),
                           .FIELD_ID_W(FIELD_ID_W)) bus ();

    tree_path_encoder #(.NODE_COUNT(NODE_COUNT), .MAX_DEPTH(MAX_DEPTH),
                        .FIELD_ID_W(FIELD_ID_W)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Root-first path of node, or err when more than MAX_DEPTH hops are needed
    function automatic void model_path(input int node, output bit e);
        int c;
        c = node;
        e = 1'b0;
        exp_q.delete();
        while (c != 0) begin
            if (exp_q.size() == MAX_DEPTH) begin
                e = 1'b1;
                break;
            end
            exp_q.push_front(fld[c]);
            c = par[c];
        end
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NODE_COUNT; i++) begin
            par[i] = 0;
            fld[i] = 0;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, bus.field_valid_o, 1'b0);
        check({tag, "_last"},  bus.field_last_o, 1'b0);
        check({tag, "_done"},  bus.done_o, 1'b0);
        check({tag, "_err"},   bus.err_o, 1'b0);
        check({tag, "_busy"},  bus.busy_o, 1'b0);
        check({tag, "_id"},    bus.field_id_o, '0);
        check({tag, "_depth"}, bus.field_depth_o, '0);
        check({tag, "_ready"}, bus.req_ready_o, 1'b1);
    endtask

    task automatic cfg_write(input int node, input int parent, input int field);
        bus.cfg_we_i       = 1'b1;
        bus.cfg_node_i     = NIW'(node);
        bus.cfg_parent_i   = NIW'(parent);
        bus.cfg_field_id_i = FIELD_ID_W'(field);
        @(posedge clk); #1;
        bus.cfg_we_i = 1'b0;
        if (node != 0 && node < NODE_COUNT) begin
            par[node] = parent;
            fld[node] = field;
        end
    endtask

    // mode: 0 ready held high, 1 ready toggling, 2 ready random
    task automatic run_request(input int node, input int mode, input bit busy_wr);
        int n, bi, guard, d;
        bit rdy, exp_err;
        model_path(node, exp_err);
        d = exp_q.size();
        check("accept_ready", bus.req_ready_o, 1'b1);
        bus.req_valid_i   = 1'b1;
        bus.req_node_i    = NIW'(node);
        bus.field_ready_i = 1'b0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        if (busy_wr) begin
            bus.cfg_we_i       = 1'b1;
            bus.cfg_node_i     = NIW'(3);
            bus.cfg_parent_i   = NIW'(2);
            bus.cfg_field_id_i = FIELD_ID_W'(20);
        end
        n = 0;
        while (!(bus.field_valid_o || bus.done_o || bus.err_o) && n < 40) begin
            @(posedge clk); #1;
            bus.cfg_we_i = 1'b0;
            n++;
        end
        bus.cfg_we_i = 1'b0;
        check("first_event_latency", n, exp_err ? MAX_DEPTH : d);
        if (exp_err) begin
            check("err_pulse", bus.err_o, 1'b1);
            check("err_no_valid", bus.field_valid_o, 1'b0);
            check("err_no_done", bus.done_o, 1'b0);
            @(posedge clk); #1;
        end else begin
            bi = 0;
            guard = 0;
            while (bi < d && guard < 200) begin
                check("beat_valid", bus.field_valid_o, 1'b1);
                check("beat_id", bus.field_id_o, exp_q[bi]);
                check("beat_depth", bus.field_depth_o, bi + 1);
                check("beat_last", bus.field_last_o, (bi == d - 1));
                check("beat_no_done", bus.done_o, 1'b0);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = guard[0];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.field_ready_i = rdy;
                @(posedge clk); #1;
                guard++;
                if (rdy) bi++;
            end
            bus.field_ready_i = 1'b0;
            check("beat_count", bi, d);
            check("done_pulse", bus.done_o, 1'b1);
            check("done_no_valid", bus.field_valid_o, 1'b0);
            @(posedge clk); #1;
        end
        check_quiet("post");
    endtask

    initial begin
        int v;
        bit e;
        clear_model();
        bus.cfg_we_i       = 1'b0;
        bus.cfg_node_i     = '0;
        bus.cfg_parent_i   = '0;
        bus.cfg_field_id_i = '0;
        bus.req_valid_i    = 1'b0;
        bus.req_node_i     = '0;
        bus.field_ready_i  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic 3-deep path, then stalled and node-0 requests
        cfg_write(1, 0, 3);
        cfg_write(2, 1, 7);
        cfg_write(3, 2, 12);
        run_request(3, 0, 1'b0);
        run_request(3, 1, 1'b0);
        run_request(0, 0, 1'b0);

        // Self loop must error out after MAX_DEPTH pushes, then recover
        cfg_write(5, 5, 9);
        run_request(5, 0, 1'b0);
        run_request(3, 0, 1'b0);

        // Write while busy is dropped; write to root is ignored
        run_request(3, 0, 1'b1);
        run_request(3, 0, 1'b0);
        cfg_write(0, 5, 9);
        run_request(3, 1, 1'b0);
        run_request(1, 0, 1'b0);

        // Full-depth chain 10..17, field 0 included
        cfg_write(10, 0, 0);
        for (int k = 11; k < 18; k++) cfg_write(k, k - 1, $urandom_range(0, 31));
        run_request(17, 0, 1'b0);
        run_request(17, 2, 1'b0);

        // Reset in the middle of EMIT
        bus.req_valid_i = 1'b1;
        bus.req_node_i  = NIW'(17);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        v = 0;
        while (!bus.field_valid_o && v < 40) begin
            @(posedge clk); #1;
            v++;
        end
        check("mid_reset_latency", v, MAX_DEPTH);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        clear_model();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("after_reset");
        model_path(17, e);
        check("model_single_beat", exp_q.size(), 1);
        run_request(17, 0, 1'b0);

        // Random trees, mostly acyclic, with occasional arbitrary parents
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k < NODE_COUNT; k++) begin
                if ($urandom_range(0, 7) == 0) v = $urandom_range(0, NODE_COUNT - 1);
                else v = $urandom_range(0, k - 1);
                cfg_write(k, v, $urandom_range(0, 31));
            end
            for (int q = 0; q < 10; q++) run_request($urandom_range(0, NODE_COUNT - 1), 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
